// File: rtl/vga_score_capture.sv
// rtl/vga_score_capture.sv - VGA stream receiver: regenerates pixel coordinates from sync edges
// and publishes per-frame match count and bounding box of a target colour.
module vga_score_capture #(
  parameter int H_SYNC_START = 656,
  parameter int V_SYNC_START = 490,
  parameter int H_TOTAL      = 800,
  parameter int V_TOTAL      = 525,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [8:0]  rgb,
  input  logic [8:0]  target,
  output logic        locked,
  output logic        frame_valid,
  output logic        sync_err,
  output logic [18:0] pix_count,
  output logic [9:0]  x_min,
  output logic [9:0]  x_max,
  output logic [9:0]  y_min,
  output logic [9:0]  y_max
);

  localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_SYNC  = 10'(H_SYNC_START);
  localparam logic [9:0]  V_SYNC  = 10'(V_SYNC_START);
  localparam logic [9:0]  H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
  localparam logic [18:0] CNT_MAX = '1;
  localparam logic [9:0]  MIN_CLR = 10'h3FF;

  typedef enum logic [1:0] {HUNT, ACQ, LOCK} state_t;

  state_t      state_q, state_d;
  logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [18:0] acc_cnt_q, acc_cnt_d;
  logic [9:0]  acc_xmin_q, acc_xmin_d, acc_xmax_q, acc_xmax_d;
  logic [9:0]  acc_ymin_q, acc_ymin_d, acc_ymax_q, acc_ymax_d;
  logic [18:0] pub_cnt_q, pub_cnt_d;
  logic [9:0]  pub_xmin_q, pub_xmin_d, pub_xmax_q, pub_xmax_d;
  logic [9:0]  pub_ymin_q, pub_ymin_d, pub_ymax_q, pub_ymax_d;
  logic        frame_valid_q, sync_err_q;

  logic        hs_fall, vs_fall, x_wrap, pos_err, pix_hit;
  logic [9:0]  x_pred, y_pred;
  logic        publish, clear_acc, err_pulse;

  // Edge detect and predicted position use the state before this pixel is applied.
  always_comb begin
    hs_fall = p_tick & hs_prev_q & ~hsync;
    vs_fall = p_tick & vs_prev_q & ~vsync;
    x_wrap  = (x_q == H_LAST);
    x_pred  = x_wrap ? 10'd0 : x_q + 10'd1;
    if (x_wrap) y_pred = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
    else        y_pred = y_q;
    pos_err = (hs_fall && (x_pred != H_SYNC)) || (vs_fall && (y_pred != V_SYNC));
    pix_hit = p_tick && (x_q < H_ACT) && (y_q < V_ACT) && (rgb == target);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= HUNT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    if (vs_fall) state_d = ACQ;
      ACQ:     if (pos_err) state_d = HUNT; else if (vs_fall) state_d = LOCK;
      LOCK:    if (pos_err) state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    publish   = (state_q != HUNT) && vs_fall && !pos_err;
    err_pulse = (state_q != HUNT) && pos_err;
    clear_acc = vs_fall && ((state_q == HUNT) || !pos_err);
  end

  always_comb begin
    hs_prev_d = hs_prev_q;
    vs_prev_d = vs_prev_q;
    x_d       = x_q;
    y_d       = y_q;
    if (p_tick) begin
      hs_prev_d = hsync;
      vs_prev_d = vsync;
      x_d       = hs_fall ? H_SYNC : x_pred;
      y_d       = vs_fall ? V_SYNC : y_pred;
    end
  end

  // Clear is applied before the hit so a cleared frame still sees a same-tick pixel.
  always_comb begin
    acc_cnt_d  = clear_acc ? 19'd0   : acc_cnt_q;
    acc_xmin_d = clear_acc ? MIN_CLR : acc_xmin_q;
    acc_xmax_d = clear_acc ? 10'd0   : acc_xmax_q;
    acc_ymin_d = clear_acc ? MIN_CLR : acc_ymin_q;
    acc_ymax_d = clear_acc ? 10'd0   : acc_ymax_q;
    if (pix_hit) begin
      if (acc_cnt_d != CNT_MAX) acc_cnt_d = acc_cnt_d + 19'd1;
      if (x_q < acc_xmin_d) acc_xmin_d = x_q;
      if (x_q > acc_xmax_d) acc_xmax_d = x_q;
      if (y_q < acc_ymin_d) acc_ymin_d = y_q;
      if (y_q > acc_ymax_d) acc_ymax_d = y_q;
    end
  end

  always_comb begin
    pub_cnt_d  = pub_cnt_q;
    pub_xmin_d = pub_xmin_q;
    pub_xmax_d = pub_xmax_q;
    pub_ymin_d = pub_ymin_q;
    pub_ymax_d = pub_ymax_q;
    if (publish) begin
      pub_cnt_d  = acc_cnt_q;
      pub_xmin_d = acc_xmin_q;
      pub_xmax_d = acc_xmax_q;
      pub_ymin_d = acc_ymin_q;
      pub_ymax_d = acc_ymax_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      acc_cnt_q     <= 19'd0;
      acc_xmin_q    <= MIN_CLR;
      acc_xmax_q    <= 10'd0;
      acc_ymin_q    <= MIN_CLR;
      acc_ymax_q    <= 10'd0;
      pub_cnt_q     <= 19'd0;
      pub_xmin_q    <= 10'd0;
      pub_xmax_q    <= 10'd0;
      pub_ymin_q    <= 10'd0;
      pub_ymax_q    <= 10'd0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      x_q           <= x_d;
      y_q           <= y_d;
      acc_cnt_q     <= acc_cnt_d;
      acc_xmin_q    <= acc_xmin_d;
      acc_xmax_q    <= acc_xmax_d;
      acc_ymin_q    <= acc_ymin_d;
      acc_ymax_q    <= acc_ymax_d;
      pub_cnt_q     <= pub_cnt_d;
      pub_xmin_q    <= pub_xmin_d;
      pub_xmax_q    <= pub_xmax_d;
      pub_ymin_q    <= pub_ymin_d;
      pub_ymax_q    <= pub_ymax_d;
      frame_valid_q <= publish;
      sync_err_q    <= err_pulse;
    end
  end

  assign locked      = (state_q == LOCK);
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign pix_count   = pub_cnt_q;
  assign x_min       = pub_xmin_q;
  assign x_max       = pub_xmax_q;
  assign y_min       = pub_ymin_q;
  assign y_max       = pub_ymax_q;

endmodule

// File: tb/tb_vga_score_capture.sv
// tb/tb_vga_score_capture.sv - scoreboard bench for vga_score_capture on a reduced raster.
module tb_vga_score_capture;

  localparam int HT = 24, HA = 16, HS = 18, HW = 3;
  localparam int VT = 14, VA = 10, VS = 11, VW = 2;
  localparam int NF = 14;

  logic        clk = 1'b0;
  logic        reset, p_tick, hsync, vsync;
  logic [8:0]  rgb, target;
  logic        locked, frame_valid, sync_err;
  logic [18:0] pix_count;
  logic [9:0]  x_min, x_max, y_min, y_max;

  always #5 clk = ~clk;

  vga_score_capture #(
    .H_SYNC_START(HS), .V_SYNC_START(VS), .H_TOTAL(HT), .V_TOTAL(VT),
    .H_ACTIVE(HA), .V_ACTIVE(VA)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
    .rgb(rgb), .target(target), .locked(locked), .frame_valid(frame_valid),
    .sync_err(sync_err), .pix_count(pix_count), .x_min(x_min), .x_max(x_max),
    .y_min(y_min), .y_max(y_max)
  );

  typedef struct { int cnt; int xmn; int xmx; int ymn; int ymx; } res_t;

  res_t fr_q[$];
  int   err_q[$];
  int   total = 0, bad = 0;

  // Reference: receiver position as the sync rules define it, plus how many
  // clean vsync falls have been seen (0 hunting, 1 acquired, 2 locked).
  int   rx, ry, lvl;
  bit   hp, vp, exp_locked;
  int   rx0, rx1, ry0, ry1;
  bit   has_rect;
  res_t cur_exp;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    rx = 0; ry = 0; hp = 1; vp = 1; lvl = 0; exp_locked = 0;
  endtask

  task automatic model_step(input bit hs, input bit vs);
    bit hf, vf, err;
    int px, py;
    hf = hp && !hs;
    vf = vp && !vs;
    px = (rx + 1) % HT;
    py = (rx == HT - 1) ? (ry + 1) % VT : ry;
    err = (hf && px != HS) || (vf && py != VS);
    rx = hf ? HS : px;
    ry = vf ? VS : py;
    hp = hs; vp = vs;
    if (lvl == 0) begin
      if (vf) lvl = 1;
    end else if (err) begin
      err_q.push_back(1);
      lvl = 0;
    end else if (vf) begin
      fr_q.push_back(cur_exp);
      lvl = 2;
    end
    exp_locked = (lvl == 2);
  endtask

  task automatic plan_frame(input int f);
    has_rect = 1;
    case (f)
      1: begin rx0 = 5; rx1 = 9; ry0 = 3; ry1 = 7; end
      2: has_rect = 0;
      3: begin rx0 = 0; rx1 = HA - 1; ry0 = 0; ry1 = VA - 1; end
      default: begin
        rx0 = $urandom_range(HA - 1, 0); rx1 = $urandom_range(HA - 1, rx0);
        ry0 = $urandom_range(VA - 1, 0); ry1 = $urandom_range(VA - 1, ry0);
        if ($urandom_range(4, 0) == 0) has_rect = 0;
      end
    endcase
    target = 9'($urandom_range(511, 0));
    if (has_rect) begin
      cur_exp.cnt = (rx1 - rx0 + 1) * (ry1 - ry0 + 1);
      cur_exp.xmn = rx0; cur_exp.xmx = rx1; cur_exp.ymn = ry0; cur_exp.ymx = ry1;
    end else begin
      cur_exp.cnt = 0; cur_exp.xmn = 1023; cur_exp.xmx = 0; cur_exp.ymn = 1023; cur_exp.ymx = 0;
    end
  endtask

  task automatic tick(input bit hs, input bit vs, input logic [8:0] pix);
    @(negedge clk);
    reset = 0; p_tick = 1; hsync = hs; vsync = vs; rgb = pix;
    model_step(hs, vs);
  endtask

  // Inputs wiggle while the strobe is low; none of it may be sampled.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      p_tick = 0;
      hsync = 1'($urandom); vsync = 1'($urandom); rgb = 9'($urandom);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_frame_valid"}, frame_valid, 0);
    chk({tag, "_sync_err"}, sync_err, 0);
    chk({tag, "_pix_count"}, pix_count, 0);
    chk({tag, "_x_min"}, x_min, 0);
    chk({tag, "_x_max"}, x_max, 0);
    chk({tag, "_y_min"}, y_min, 0);
    chk({tag, "_y_max"}, y_max, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    p_tick = 0; reset = 1;
    model_reset();
    @(posedge clk); #1;
    check_reset_outputs("midreset");
  endtask

  initial begin : monitor
    res_t r;
    forever begin
      @(posedge clk); #1;
      chk("locked", locked, exp_locked);
      chk("frame_valid", frame_valid, fr_q.size() != 0);
      if (fr_q.size() != 0) begin
        r = fr_q.pop_front();
        if (frame_valid) begin
          chk("pix_count", pix_count, r.cnt);
          chk("x_min", x_min, r.xmn);
          chk("x_max", x_max, r.xmx);
          chk("y_min", y_min, r.ymn);
          chk("y_max", y_max, r.ymx);
        end
      end
      chk("sync_err", sync_err, err_q.size() != 0);
      if (err_q.size() != 0) void'(err_q.pop_front());
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : driver
    int len, nx, ny;
    bit hs, vs, in_rect;
    logic [8:0] pix;
    reset = 1; p_tick = 0; hsync = 1; vsync = 1; rgb = 0; target = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    for (int f = 0; f < NF; f++) begin
      plan_frame(f);
      for (int gy = 0; gy < VT; gy++) begin
        len = ((f == 4 && gy == 2) || (f == 10 && gy == VS - 1)) ? HT - 1 : HT;
        for (int gx = 0; gx < len; gx++) begin
          if (f == 6 && gy == 4 && gx == 7) idle(100);
          if (f == 7 && gy == 4 && gx == 3) do_reset();
          nx = (gx == len - 1) ? 0 : gx + 1;
          ny = (gx == len - 1) ? (gy + 1) % VT : gy;
          hs = !(nx >= HS && nx < HS + HW);
          vs = !(ny >= VS && ny < VS + VW);
          in_rect = has_rect && gx < HA && gy < VA &&
                    gx >= rx0 && gx <= rx1 && gy >= ry0 && gy <= ry1;
          if (in_rect) pix = target;
          else if (gx < HA && gy < VA) begin
            pix = 9'($urandom);
            if (pix == target) pix = pix ^ 9'h001;
          end else pix = 9'($urandom);
          tick(hs, vs, pix);
          idle(($urandom_range(3, 0) == 0) ? $urandom_range(3, 2) : 1);
        end
      end
    end
    idle(5);
    chk("frame_queue_drained", fr_q.size(), 0);
    chk("err_queue_drained", err_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
